// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults for the fetch queue unit: widths, reset PC and entry record width.
package fetch_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned IMEM_DEPTH_DEF = 128;
  localparam int unsigned Q_DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

  // A queue entry is the record {pc, ir}, each XLEN wide.
  localparam int unsigned ENTRY_W_DEF    = 2 * XLEN_DEF;

  function automatic int unsigned entry_w(input int unsigned xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Fetch queue unit bus: redirect inputs, instruction-memory load port,
// consumer handshake and queue head/occupancy outputs.
//   master : driver of fetch_en/redirects/imem load/out_ready (consumer side)
//   slave  : the fetch queue unit itself
interface fetch_queue_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned Q_DEPTH    = Q_DEPTH_DEF
);

  localparam int unsigned IW  = $clog2(IMEM_DEPTH);
  localparam int unsigned QCW = $clog2(Q_DEPTH) + 1;

  logic            fetch_en;
  logic            branch;
  logic            jump;
  logic [XLEN-1:0] branch_addr;
  logic [XLEN-1:0] jump_addr;
  logic            imem_we;
  logic [IW-1:0]   imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ir;
  logic [QCW-1:0]  q_count;

  modport master (
    output fetch_en, branch, jump, branch_addr, jump_addr,
           imem_we, imem_waddr, imem_wdata, out_ready,
    input  out_valid, out_pc, out_ir, q_count
  );

  modport slave (
    input  fetch_en, branch, jump, branch_addr, jump_addr,
           imem_we, imem_waddr, imem_wdata, out_ready,
    output out_valid, out_pc, out_ir, q_count
  );

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: circular entry queue with flush and registered head.
//   i_push/i_pop/i_flush : queue controls (flush wins over push/pop)
//   i_din                : entry to enqueue
//   o_valid/o_dout       : registered head; o_dout holds when empty
//   o_count              : occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DW    = ENTRY_W_DEF,
  parameter int unsigned DEPTH = Q_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [DW-1:0]              i_din,
  output logic                       o_valid,
  output logic [DW-1:0]              o_dout,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_head;
  logic          r_valid;

  logic          w_pop;
  logic [PW-1:0] w_rd_nxt;
  logic [CW-1:0] w_count_nxt;

  // Pop on empty is a no-op.
  assign w_pop       = i_pop && (r_count != '0);
  assign w_rd_nxt    = r_rd_ptr + PW'(w_pop);
  assign w_count_nxt = r_count + CW'(i_push) - CW'(w_pop);

  // Storage is not reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (rst && !i_flush && i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      // New head: the incoming entry if nothing older survives, else the
      // next stored slot. Head is held when the queue goes empty.
      if (w_count_nxt != '0) begin
        r_head <= (r_count == CW'(w_pop)) ? i_din : r_mem[w_rd_nxt];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_dout  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC register + instruction memory feeding a fetch queue.
//   clk, rst     : clock, synchronous active-low reset
//   bus (slave)  : fetch_en, branch/jump redirects, imem load port,
//                  out_ready handshake, out_valid/out_pc/out_ir head, q_count
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter int unsigned     IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter int unsigned     Q_DEPTH    = Q_DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF)
) (
  input logic               clk,
  input logic               rst,
  fetch_queue_unit_if.slave bus
);

  localparam int unsigned IW  = $clog2(IMEM_DEPTH);
  localparam int unsigned QCW = $clog2(Q_DEPTH) + 1;
  localparam int unsigned EW  = entry_w(XLEN);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imem [IMEM_DEPTH];

  logic [IW-1:0]   w_idx;
  logic [XLEN-1:0] w_ir;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_valid;
  logic [EW-1:0]   w_head;
  logic [QCW-1:0]  w_count;

  // Word index; upper PC bits wrap modulo the memory depth.
  assign w_idx = r_pc[IW+1:2];
  assign w_ir  = r_imem[w_idx];

  // Branch has priority over jump; targets are forced word aligned.
  assign w_redirect = bus.branch || bus.jump;
  assign w_target   = (bus.branch ? bus.branch_addr : bus.jump_addr) & ~XLEN'(3);

  assign w_full = (w_count == QCW'(Q_DEPTH));
  assign w_pop  = w_valid && bus.out_ready;
  assign w_push = bus.fetch_en && !w_redirect && (!w_full || w_pop);

  // Fetch PC.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_push) begin
      r_pc <= r_pc + XLEN'(4);
    end
  end

  // Instruction memory load port; a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (rst && bus.imem_we) begin
      r_imem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  fetch_fifo #(
    .DW    (EW),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_din   ({r_pc, w_ir}),
    .o_valid (w_valid),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign bus.out_valid = w_valid;
  assign bus.out_pc    = w_head[EW-1:XLEN];
  assign bus.out_ir    = w_head[XLEN-1:0];
  assign bus.q_count   = w_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit.
module tb_fetch_queue_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NW   = 32;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  logic [31:0] exp_mem [NW];

  fetch_queue_unit_if #(.XLEN(32), .IMEM_DEPTH(128), .Q_DEPTH(4)) bus ();

  fetch_queue_unit #(
    .XLEN       (32),
    .IMEM_DEPTH (128),
    .Q_DEPTH    (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ir, input logic [2:0] cnt);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    check({tag, ".pc"},    64'(bus.out_pc),    64'(pc));
    check({tag, ".ir"},    64'(bus.out_ir),    64'(ir));
    check({tag, ".count"}, 64'(bus.q_count),   64'(cnt));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.fetch_en    = 1'b0;
    bus.branch      = 1'b0;
    bus.jump        = 1'b0;
    bus.branch_addr = '0;
    bus.jump_addr   = '0;
    bus.imem_we     = 1'b0;
    bus.imem_waddr  = '0;
    bus.imem_wdata  = '0;
    bus.out_ready   = 1'b0;
    for (int i = 0; i < NW; i++) exp_mem[i] = 32'hA000_0000 + 32'(i) * 32'h0101;

    tick();
    tick();
    check_head("reset", 1'b0, 32'h0, 32'h0, 3'd0);

    // Load memory with fetching disabled; pop on empty is a no-op.
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 7'(i);
      bus.imem_wdata = exp_mem[i];
      tick();
    end
    bus.imem_we = 1'b0;
    check_head("idle_pop_empty", 1'b0, 32'h0, 32'h0, 3'd0);

    // Streaming: one instruction per cycle, first valid one cycle after enable.
    bus.fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_head($sformatf("stream%0d", i), 1'b1, 32'(4 * i), exp_mem[i], 3'd1);
    end

    // Stall: queue saturates at 4 and PC stops at 16.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_head("stall_full", 1'b1, 32'h0, exp_mem[0], 3'd4);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_head($sformatf("drain%0d", i), 1'b1, 32'(4 * i), exp_mem[i], 3'd4);
    end

    // Branch beats jump with 3 queued; handshake in the flush cycle.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("three_queued", 64'(bus.q_count), 64'd3);
    bus.branch      = 1'b1;
    bus.branch_addr = 32'h40;
    bus.jump        = 1'b1;
    bus.jump_addr   = 32'h80;
    bus.out_ready   = 1'b1;
    tick();
    check_head("flush", 1'b0, 32'h0, exp_mem[0], 3'd0);
    bus.branch = 1'b0;
    bus.jump   = 1'b0;
    tick();
    check_head("branch_tgt", 1'b1, 32'h40, exp_mem[16], 3'd1);

    // Unaligned jump target wraps to index 0; same-cycle write returns old word.
    bus.jump      = 1'b1;
    bus.jump_addr = 32'h203;
    tick();
    check("jump_flush.valid", 64'(bus.out_valid), 64'd0);
    bus.jump       = 1'b0;
    bus.imem_we    = 1'b1;
    bus.imem_waddr = 7'd0;
    bus.imem_wdata = 32'h1234_5678;
    tick();
    bus.imem_we = 1'b0;
    check_head("jump_tgt", 1'b1, 32'h200, exp_mem[0], 3'd1);
    exp_mem[0] = 32'h1234_5678;
    tick();
    check_head("jump_next", 1'b1, 32'h204, exp_mem[1], 3'd1);

    // Reset while full discards entries but keeps memory.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("prefull.count", 64'(bus.q_count), 64'd4);
    rst = 1'b0;
    tick();
    check_head("mid_reset", 1'b0, 32'h0, 32'h0, 3'd0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check_head("post_reset", 1'b1, 32'h0, exp_mem[0], 3'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC, instruction and target width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 128, meaning instruction memory depth in words (power of 2).
REQ-003 SHALL have parameter Q_DEPTH, default 4, meaning fetch queue depth in entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset (word aligned).
REQ-005 SHALL have port clk  in  1  meaning the single clock, rising edge.
REQ-006 SHALL have port rst  in  1  meaning reset, synchronous, active-low.
REQ-007 SHALL have port fetch_en  in  1  meaning fetching permitted when 1.
REQ-008 SHALL have ports branch, jump  in  1 each  meaning redirect requests.
REQ-009 SHALL have ports branch_addr, jump_addr  in  XLEN each  meaning redirect targets.
REQ-010 SHALL have ports imem_we  in  1, imem_waddr  in  log2(IMEM_DEPTH), imem_wdata  in  XLEN  meaning instruction memory load port.
REQ-011 SHALL have port out_ready  in  1  meaning consumer accepts the head entry.
REQ-012 SHALL have ports out_valid  out  1, out_pc  out  XLEN, out_ir  out  XLEN  meaning head entry of the queue.
REQ-013 SHALL have port q_count  out  log2(Q_DEPTH)+1  meaning current queue occupancy.

Function
REQ-014 SHALL hold the fetch PC in a register and index memory with PC[log2(IMEM_DEPTH)+1:2]; upper PC bits are ignored (index wraps modulo IMEM_DEPTH).
REQ-015 SHALL read memory combinationally; the entry {PC, mem[index]} is pushed at the clock edge, so an instruction appears on out_* one cycle after its PC is current.
REQ-016 SHALL push when fetch_en=1, no redirect, and (queue not full or a pop occurs in the same cycle); on push PC <= PC+4 (mod 2^XLEN).
REQ-017 SHALL hold PC unchanged when no push and no redirect occur.
REQ-018 SHALL pop the head when out_valid=1 and out_ready=1; out_valid = (q_count != 0).
REQ-019 SHALL, on redirect, take branch over jump when both are 1, load PC with target and bits [1:0] forced to 0, clear the queue (q_count <= 0) and push nothing that cycle.
REQ-020 SHALL treat a handshake in a redirect cycle as completed for the consumer; the flush still empties the queue.
REQ-021 SHALL support simultaneous push and pop when full; q_count is unchanged.
REQ-022 SHALL keep pop on empty a no-op; out_pc/out_ir hold their last value when out_valid=0.
REQ-023 SHALL write mem[imem_waddr] <= imem_wdata on imem_we; a fetch of the same index in that cycle returns the old word.
REQ-024 SHALL keep read/write pointers of width log2(Q_DEPTH) wrapping naturally, with occupancy tracked by q_count.

Reset
REQ-025 SHALL, when rst=0 at a rising clk, set PC <= RESET_PC, q_count <= 0, out_valid = 0, out_pc = 0, out_ir = 0, pointers <= 0.
REQ-026 SHALL give reset priority over redirect, push, pop and memory write; reset mid-operation discards all queued entries.
REQ-027 SHALL leave instruction memory contents unaffected by reset.

Structure
REQ-028 SHALL place default widths, RESET_PC and the entry record {pc, ir} width in a shared package fetch_pkg.
REQ-029 SHALL implement the queue as sub-module fetch_fifo (push, pop, flush, data in/out, count); PC and memory live in the top.

Verification
REQ-030 SHALL cover: reset, mem[0..3]=A,B,C,D, fetch_en=1, out_ready=1 -> out_valid first high cycle 1, pcs 0,4,8,12 with ir A..D one per cycle.
REQ-031 SHALL cover: out_ready=0 for 10 cycles -> q_count saturates at 4, PC stops at 16, then out_ready=1 drains 0,4,8,12 in order.
REQ-032 SHALL cover: branch=1 (0x40) and jump=1 (0x80) same cycle with 3 queued -> q_count=0 next cycle, next out_pc=0x40.
REQ-033 SHALL cover: jump_addr=0x203 with IMEM_DEPTH=128 -> PC=0x200, fetched word is mem[0].
REQ-034 SHALL cover: rst=0 asserted for one cycle while full -> out_valid=0, q_count=0, next out_pc=RESET_PC; memory contents retained.
